// File: rtl/maxpool_stream.sv
// rtl/maxpool_stream.sv - streaming 1-D max-pool over non-overlapping windows of POOL samples; optional MAXPOOL_FLUSH_PARTIAL_EN
module maxpool_stream #(
    parameter int WIDTH = 16,
    parameter int N_IN  = 32,
    parameter int POOL  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x_data,
    input  logic             x_valid,
    output logic             x_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             y_last
);

    localparam int CW = $clog2(N_IN);
    localparam int WW = $clog2(POOL);

    logic [WIDTH-1:0] r_cur_max;
    logic [WW-1:0]    r_win_cnt;
    logic [CW-1:0]    r_in_cnt;
    logic [WIDTH-1:0] r_y_data;
    logic             r_y_valid;
    logic             r_y_last;

    logic             w_accept;
    logic             w_win_end;
    logic             w_frame_end;
    logic             w_close;
    logic             w_close_last;
    logic [WIDTH-1:0] w_max;

    assign x_ready     = ~r_y_valid | y_ready;
    assign w_accept    = x_valid & x_ready;
    assign w_win_end   = (r_win_cnt == WW'(POOL - 1));
    assign w_frame_end = (r_in_cnt == CW'(N_IN - 1));

`ifdef MAXPOOL_FLUSH_PARTIAL_EN
    // The trailing partial window closes on the frame's last sample.
    assign w_close      = w_win_end | w_frame_end;
    assign w_close_last = w_frame_end;
`else
    // The trailing partial window is dropped, so the frame marker rides on the last full window.
    localparam int LAST_FULL_IDX = (N_IN / POOL) * POOL - 1;
    assign w_close      = w_win_end;
    assign w_close_last = (r_in_cnt == CW'(LAST_FULL_IDX));
`endif

    // Running max including the sample being accepted this cycle.
    always_comb begin
        w_max = x_data;
        if (r_win_cnt != '0 && $signed(r_cur_max) >= $signed(x_data)) begin
            w_max = r_cur_max;
        end
    end

    // Window accumulator and window/frame counters; windows restart at each frame wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cur_max <= '0;
            r_win_cnt <= '0;
            r_in_cnt  <= '0;
        end else if (w_accept) begin
            r_cur_max <= w_max;
            if (w_close || w_frame_end) begin
                r_win_cnt <= '0;
            end else begin
                r_win_cnt <= r_win_cnt + WW'(1);
            end
            if (w_frame_end) begin
                r_in_cnt <= '0;
            end else begin
                r_in_cnt <= r_in_cnt + CW'(1);
            end
        end
    end

    // Output register: load on window close, otherwise drain on transfer, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_y_data  <= '0;
            r_y_valid <= 1'b0;
            r_y_last  <= 1'b0;
        end else if (w_accept && w_close) begin
            r_y_data  <= w_max;
            r_y_valid <= 1'b1;
            r_y_last  <= w_close_last;
        end else if (r_y_valid && y_ready) begin
            r_y_valid <= 1'b0;
            r_y_last  <= 1'b0;
        end
    end

    assign y_data  = r_y_data;
    assign y_valid = r_y_valid;
    assign y_last  = r_y_last;

endmodule
